digit_seq_encoder: RTL
======================

# digit_seq_encoder

Stimulus-side counterpart of the digit-sequence FSM (trabalho2/questao_1). That FSM consumes a 2-bit symbol `a` per clock and presents a 3-bit digit. This block works in the other direction: it accepts a stream of target digits and produces, per digit, the symbol `a` that steers the FSM to that digit. It keeps an internal mirror of the FSM state to do so. It sits in front of the FSM in benches and in the board demo, so a digit string can be typed in directly instead of hand-encoded symbol sequences.

## Interface
- `FIFO_DEPTH`, default 4: target-digit buffer depth; power of two, ≥2.
- `ERR_W`, default 8: width of the error counter.
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `tgt_valid`, input, 1: target digit offered.
- `tgt_ready`, output, 1: buffer can accept a digit.
- `tgt_digit`, input, 3: target digit, 0..7.
- `sym_valid`, output, 1: `sym` holds a symbol.
- `sym_ready`, input, 1: consumer takes `sym`.
- `sym`, output, 2: symbol to apply to the FSM input `a`.
- `err`, output, 1: one-cycle pulse when a target was unreachable.
- `err_count`, output, `ERR_W`: saturating count of unreachable targets.
- `cur_digit`, output, 3: digit the mirrored FSM presents.

## Operation
- **Mirror states:** S0, S1, S2, S4, S3, S5, S6, S3T. S3T is the second "3".
- **Mirror output digits:** S0→0, S1→1, S2→2, S4→4, S3→3, S3T→3, S5→5, S6→6.
- **Mirror transitions (next state for a=0 / a=1 / a=2 / a=3):**
  - S0: S1 / S2 / S2 / S3.
  - S1: S2 / S2 / S3 / S3.
  - S2: S0 / S4 / S3T / S3.
  - S4: S2 / S3 / S3 / S3.
  - S3: S2 / S2 / S2 / S5.
  - S5: S2 / S2 / S2 / S6.
  - S6: S2 / S2 / S2 / S3.
  - S3T: S2 / S2 / S1 / S3.
- **Target buffer:** accepted targets go into a FIFO.
  - A push happens when `tgt_valid && tgt_ready`.
  - `tgt_ready = !full`. A pop in the same cycle does not free a slot for that cycle's push.
- **Encode step:** runs when the FIFO is non-empty and the symbol register is free, i.e. `!sym_valid || sym_ready`.
  - The head target is evaluated against the mirror state.
  - Candidates are a = 0,1,2,3 in ascending order. The first a whose next state outputs the target digit wins.
  - Ties, e.g. S2 with target 3, resolve to the smallest a; S2 with target 3 therefore gives a=2 (S3T).
- **Success:**
  - pop the head;
  - load `sym` and set `sym_valid`;
  - advance the mirror to the chosen next state.
- **Failure (no candidate; digit 7 always fails):**
  - pop the head;
  - no symbol is emitted;
  - the mirror is unchanged;
  - `err` pulses for one cycle;
  - `err_count` increments and saturates at all-ones.
- **Symbol hold:** `sym` and `sym_valid` stay stable while `sym_valid && !sym_ready`.
- **Mirror-advance assumption:** the mirror advances when the symbol is produced, not when it is consumed. The consumer must apply every symbol to the FSM, in order, one per FSM clock.

## Timing
- **Reset values:**
  - FIFO empty, so `tgt_ready=1`;
  - `sym_valid=0`, `sym=0`;
  - `err=0`, `err_count=0`;
  - mirror in S0, so `cur_digit=0`.
- **Reset mid-operation** discards buffered targets and any pending symbol immediately (asynchronously).
- **Latency:** a target accepted at edge k produces `sym_valid` after edge k+1, provided the FIFO was empty and the symbol register was free.
- **Throughput:** one symbol per cycle while `sym_ready=1` and targets keep arriving.
- **`err` timing:** asserted after the failing edge, deasserted after the next edge. Back-to-back failures hold `err` high for consecutive cycles, one cycle per failure.
- **`cur_digit`** is registered and updates on the same edge as `sym_valid`.
- **Simultaneous FIFO push and pop** are both honoured. Count stays the same, and the pointers wrap modulo `FIFO_DEPTH`.

## Structure
- **Shared package** `digit_fsm_pkg` holds:
  - state encoding constants: S0=0, S1=1, S2=2, S4=3, S3=4, S5=5, S6=6, S3T=7;
  - a `next_state(state, a)` function;
  - a `digit_of(state)` function.
  
  The FSM and its scoreboard reuse the same package.
- **Sub-module** `digit_fifo`: synchronous FIFO with asynchronous active-low reset, parameterised width and depth.
- **Top level** holds the encode step, the mirror state register, the symbol register and the error counter.

## Test plan
- **Path:** after reset, push 1,2,4,3,5,6,3 with `sym_ready=1` → `sym` = 0,0,1,1,3,3,3; final `cur_digit`=3; `err_count`=0.
- **Tie/S3T:** push 2,3,1 → `sym` = 1,2,2; mirror states S2, S3T, S1.
- **Unreachable:** from S0, push 4 then 7 → no symbols, two `err` pulses, `err_count`=2, `cur_digit`=0. Then push 1 → `sym`=0.
- **Backpressure:** hold `sym_ready=0` and push 5 digits → `tgt_ready` drops after 4 buffered plus 1 held, and `sym` stays stable. Release → symbols drain in order.
- **Saturation:** with `ERR_W`=2, push 7 five times → `err_count` sticks at 3.
- **Reset mid-stream:** assert `reset` with 3 targets buffered and `sym_valid`=1 → all outputs return to reset values. Next target 0 → `err`, since S0 cannot reach 0.

Source files
------------

// File: rtl/digit_fsm_pkg.sv
// Shared definitions for the digit-sequence FSM, its encoder and scoreboard.
// State encoding, transition table and digit decode live here only.
package digit_fsm_pkg;

  localparam int DIGIT_W = 3;
  localparam int SYM_W   = 2;

  typedef enum logic [2:0] {
    S0  = 3'd0,
    S1  = 3'd1,
    S2  = 3'd2,
    S4  = 3'd3,
    S3  = 3'd4,
    S5  = 3'd5,
    S6  = 3'd6,
    S3T = 3'd7
  } state_t;

  function automatic state_t next_state(
    input state_t           s,
    input logic [SYM_W-1:0] a
  );
    state_t n;
    n = S0;
    unique case (s)
      S0:  n = (a == 2'd0) ? S1 :
               (a == 2'd3) ? S3 : S2;
      S1:  n = a[1] ? S3 : S2;
      S2: begin
        unique case (a)
          2'd0: n = S0;
          2'd1: n = S4;
          2'd2: n = S3T;
          2'd3: n = S3;
        endcase
      end
      S4:  n = (a == 2'd0) ? S2 : S3;
      S3:  n = (a == 2'd3) ? S5 : S2;
      S5:  n = (a == 2'd3) ? S6 : S2;
      S6:  n = (a == 2'd3) ? S3 : S2;
      S3T: n = (a == 2'd2) ? S1 :
               (a == 2'd3) ? S3 : S2;
    endcase
    return n;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_of(
    input state_t s
  );
    logic [DIGIT_W-1:0] d;
    d = '0;
    unique case (s)
      S0:  d = 3'd0;
      S1:  d = 3'd1;
      S2:  d = 3'd2;
      S4:  d = 3'd4;
      S3:  d = 3'd3;
      S5:  d = 3'd5;
      S6:  d = 3'd6;
      S3T: d = 3'd3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/digit_fifo.sv
// Synchronous FIFO; a pop never frees a slot for a push in the same cycle.
// Pointers wrap naturally because DEPTH is a power of two.
module digit_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/digit_seq_encoder.sv
// Turns a stream of target digits into FSM input symbols using a
// mirror of the FSM state; unreachable targets are dropped and counted.
import digit_fsm_pkg::*;

module digit_seq_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [2:0]       tgt_digit,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [1:0]       sym,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       cur_digit
);

  state_t     state;
  state_t     nxt;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] head;
  logic       step;
  logic       found;
  logic [1:0] a_sel;

  digit_fifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tgt_valid),
    .pop   (step),
    .wdata (tgt_digit),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tgt_ready = !fifo_full;
  assign step      = !fifo_empty && (!sym_valid || sym_ready);
  assign cur_digit = digit_of(state);

  // Descending scan so the smallest matching symbol is the one kept.
  always_comb begin
    found = 1'b0;
    a_sel = '0;
    nxt   = state;
    for (int i = 3; i >= 0; i--) begin
      if (digit_of(next_state(state, 2'(i))) == head) begin
        found = 1'b1;
        a_sel = 2'(i);
        nxt   = next_state(state, 2'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S0;
      sym_valid <= 1'b0;
      sym       <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= step && !found;
      if (sym_ready) sym_valid <= 1'b0;
      if (step && found) begin
        sym_valid <= 1'b1;
        sym       <= a_sel;
        state     <= nxt;
      end
      if (step && !found && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
